// File: rtl/mem_access_ctrl.sv
// Single-outstanding read/write sequencer in front of a synchronous RAM with registered output.
// Define MEM_WRITE_VERIFY_EN to read back every write and flag mismatches on err.
module mem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  input  logic [DATA_W-1:0] ram_dataout
);

  localparam int CNT_W = 3;

`ifdef MEM_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_VRD    = 3'd3,
    S_VWAIT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_we_q, op_we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               done_q, done_d;
  logic               accept;
  logic               rd_finish;
  logic               wr_finish;

  // State register plus the registered datapath; everything clears on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the counter is shared by the read wait and the verify wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (op_we_q) begin
`ifdef MEM_WRITE_VERIFY_EN
          state_d = S_VRD;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef MEM_WRITE_VERIFY_EN
      S_VRD: begin
        state_d = S_VWAIT;
        cnt_d   = CNT_W'(RD_LAT);
      end
      S_VWAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and completion; req outside IDLE is simply not looked at.
  always_comb begin
    accept    = (state_q == S_IDLE) && req;
    op_we_d   = accept ? we    : op_we_q;
    addr_d    = accept ? addr  : addr_q;
    wdata_d   = accept ? wdata : wdata_q;
    rd_finish = (state_q == S_WAIT) && (cnt_q <= CNT_W'(1));
`ifdef MEM_WRITE_VERIFY_EN
    wr_finish = (state_q == S_VWAIT) && (cnt_q <= CNT_W'(1));
`else
    wr_finish = (state_q == S_ACCESS) && op_we_q;
`endif
    rdata_d   = rd_finish ? ram_dataout : rdata_q;
    done_d    = rd_finish || wr_finish;
  end

  // Outputs decoded from state so reset drops the strobes immediately.
  always_comb begin
    busy      = (state_q != S_IDLE);
    ram_write = (state_q == S_ACCESS) && op_we_q;
    ram_read  = (state_q == S_ACCESS) && !op_we_q;
`ifdef MEM_WRITE_VERIFY_EN
    if (state_q == S_VRD) ram_read = 1'b1;
`endif
  end

  assign done        = done_q;
  assign rdata       = rdata_q;
  assign ram_address = addr_q;
  assign ram_datain  = wdata_q;

`ifdef MEM_WRITE_VERIFY_EN
  logic err_q, err_d;

  // err is only ever set together with a verify completion, so it reads 0 otherwise.
  always_comb begin
    err_d = wr_finish && (ram_dataout != wdata_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, multi-cycle corner cases and
// random transactions against a word-level memory reference model.
module tb_mem_access_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RD_LAT = 1;
`ifdef MEM_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  // Cycles from the request cycle to the done cycle.
  localparam int RD_CYC = RD_LAT + 2;
  localparam int WR_CYC = VERIFY ? RD_LAT + 3 : 2;

  logic          clock, reset_n, req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy, done, err, ram_read, ram_write;
  logic [DW-1:0] rdata, ram_datain;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_dataout;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_datain(ram_datain), .ram_dataout(ram_dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: synchronous write, registered read output, optional bit-flip fault.
  logic [DW-1:0] ram_mem [512];
  bit            ram_clear = 1'b1;
  bit            flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  initial ram_dataout = '0;
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= '0;
    end else begin
      if (ram_write) ram_mem[ram_address] <= ram_datain;
      if (ram_read)
        ram_dataout <= ram_mem[ram_address] ^
                       ((flip_en && ram_address == flip_addr) ? 32'h1 : 32'h0);
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] ref_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && reset_n) begin
      check("strobe_exclusive", 32'(ram_read & ram_write), 0);
      check("strobe_only_busy", 32'((ram_read | ram_write) & ~busy), 0);
      check("err_only_with_done", 32'(err & ~done), 0);
    end
  end

  // Issue one request in the current cycle and follow it to its done cycle.
  // Returns at the negedge of the done cycle, so a following call is back-to-back.
  task automatic do_access(input string tag, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                           input int exp_lat, input logic exp_err);
    int lat;
    bit got;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clock); #1;
    req = 1'b0; we = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
    @(negedge clock);
    lat = 1;
    got = 0;
    check({tag, "_access_busy"}, 32'(busy), 1);
    check({tag, "_access_wr"}, 32'(ram_write), 32'(w));
    check({tag, "_access_rd"}, 32'(ram_read), 32'(!w));
    while (!got && lat < 20) begin
      if (done) got = 1;
      else begin
        @(negedge clock);
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_busy_in_done"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_addr_hold"}, 32'(ram_address), 32'(a));
    check({tag, "_data_hold"}, ram_datain, d);
    $display("txn %s we=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
             tag, w, a, d, lat, rdata, err);
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dcnt, bcnt, n_gap;
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd, erd;

    vecs[0] = '{1'b1, 9'h005, 32'hDEADBEEF, 32'h00000000, WR_CYC};
    vecs[1] = '{1'b0, 9'h005, 32'h00000000, 32'hDEADBEEF, RD_CYC};
    vecs[2] = '{1'b1, 9'h1FF, 32'h12345678, 32'hDEADBEEF, WR_CYC};
    vecs[3] = '{1'b0, 9'h1FF, 32'h00000000, 32'h12345678, RD_CYC};
    vecs[4] = '{1'b1, 9'h000, 32'h00000001, 32'h12345678, WR_CYC};
    vecs[5] = '{1'b0, 9'h000, 32'hFFFFFFFF, 32'h00000001, RD_CYC};
    vecs[6] = '{1'b0, 9'h005, 32'h00000000, 32'hDEADBEEF, RD_CYC};
    vecs[7] = '{1'b1, 9'h010, 32'hCAFEF00D, 32'hDEADBEEF, WR_CYC};

    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    ref_rdata = '0;

    reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1 ram_clear = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Idle after reset: everything quiet for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_strobes", 32'({ram_read, ram_write}), 0);
      check("rst_err", 32'(err), 0);
    end
    check("rst_rdata", rdata, 0);
    check("rst_addr", 32'(ram_address), 0);
    check("rst_datain", ram_datain, 0);
    mon_en = 1;

    // Directed table, applied back-to-back (each request in the previous done cycle).
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d,
                vecs[i].exp_rd, vecs[i].exp_lat, 1'b0);
      if (vecs[i].w) ref_mem[vecs[i].a] = vecs[i].d;
      else           ref_rdata = ref_mem[vecs[i].a];
    end

    // req pulsed during WAIT is dropped.
    @(negedge clock);
    req = 1'b1; we = 1'b0; addr = 9'h005;
    @(posedge clock); #1 req = 1'b0;
    @(posedge clock); #1;
    req = 1'b1; we = 1'b1; addr = 9'h0AA; wdata = 32'h0;
    @(posedge clock); #1 req = 1'b0;
    @(negedge clock);
    check("wait_req_done", 32'(done), 1);
    check("wait_req_rdata", rdata, 32'hDEADBEEF);
    check("wait_req_addr", 32'(ram_address), 32'h005);
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      dcnt += int'(done);
      bcnt += int'(busy);
    end
    check("wait_req_extra_done", dcnt, 0);
    check("wait_req_no_busy", bcnt, 0);
    ref_rdata = 32'hDEADBEEF;
    $display("txn wait_req_drop addr=%h rdata=%h", ram_address, rdata);

    // Reset during WAIT of a read.
    @(negedge clock);
    req = 1'b1; we = 1'b0; addr = 9'h010;
    @(posedge clock); #1 req = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("rstwait_busy", 32'(busy), 0);
    check("rstwait_strobes", 32'({ram_read, ram_write}), 0);
    check("rstwait_done", 32'(done), 0);
    check("rstwait_rdata", rdata, 0);
    check("rstwait_addr", 32'(ram_address), 0);
    @(negedge clock);
    reset_n = 1'b1;
    ref_rdata = '0;
    $display("txn reset_in_wait rdata=%h busy=%0d", rdata, busy);

    // Reset during ACCESS of a write: the write must not reach the RAM.
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 9'h010; wdata = 32'h0BADBAD0;
    @(posedge clock); #1 req = 1'b0;
    check("rstacc_write_seen", 32'(ram_write), 1);
    reset_n = 1'b0;
    #1;
    check("rstacc_write", 32'(ram_write), 0);
    check("rstacc_busy", 32'(busy), 0);
    check("rstacc_datain", ram_datain, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    $display("txn reset_in_access busy=%0d ram_write=%0d", busy, ram_write);
    @(negedge clock);
    do_access("rd_after_abort", 1'b0, 9'h010, 32'h0, ref_mem[9'h010], RD_CYC, 1'b0);
    ref_rdata = ref_mem[9'h010];

`ifdef MEM_WRITE_VERIFY_EN
    @(negedge clock);
    do_access("verify_ok", 1'b1, 9'h020, 32'hA5A5A5A5, ref_rdata, WR_CYC, 1'b0);
    ref_mem[9'h020] = 32'hA5A5A5A5;
    flip_en = 1'b1; flip_addr = 9'h020;
    @(negedge clock);
    do_access("verify_flip", 1'b1, 9'h020, 32'hA5A5A5A5, ref_rdata, WR_CYC, 1'b1);
    flip_en = 1'b0;
`endif

    // Random traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      n_gap = $urandom_range(0, 2);
      repeat (n_gap) @(negedge clock);
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       ra = 9'h1FF;
        1:       ra = 9'h000;
        default: ra = AW'($urandom_range(0, 31));
      endcase
      rd = $urandom;
      erd = rw ? ref_rdata : ref_mem[ra];
      do_access($sformatf("rnd%0d", t), rw, ra, rd, erd, rw ? WR_CYC : RD_CYC, 1'b0);
      if (rw) ref_mem[ra] = rd;
      else    ref_rdata = ref_mem[ra];
    end

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller sitting directly upstream of the 512x32 synchronous RAM. It accepts single-word read/write requests from the CPU datapath (MAR/MDR side), sequences the RAM `Read`/`Write` strobes, and waits out the RAM's registered-output latency. Read data is captured into a holding register and completion is signalled with a one-cycle `done` pulse. Exactly one access is in flight at a time; there is no queueing.

## Interface
- `ADDR_W`, 9: word address width; matches RAM depth of 512.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: RAM read latency in WAIT cycles. Legal range 1..7.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_W  word address; sampled with `req`.
- `wdata`  in  DATA_W  write data; sampled with `req`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  last read data; holds until the next read completes.
- `err`  out  1  write-verify mismatch. Constant 0 unless the verify feature is compiled in.
- `ram_read`  out  1  drives RAM `Read`.
- `ram_write`  out  1  drives RAM `Write`.
- `ram_address`  out  ADDR_W  drives RAM `address`.
- `ram_datain`  out  DATA_W  drives RAM `DataIn`.
- `ram_dataout`  in  DATA_W  from RAM `DataOut`.

## Operation
- FSM states: IDLE, ACCESS, WAIT, VRD, VWAIT. VRD and VWAIT exist only with the verify feature.
- IDLE, `req`=1 at an edge: latch `addr`→`ram_address`, `wdata`→`ram_datain`, `we`→internal op; go to ACCESS. `req`=0: stay in IDLE.
- ACCESS: drive exactly one of `ram_write` (op=write) or `ram_read` (op=read) for one cycle.
  - Read: go to WAIT with the latency counter loaded to `RD_LAT`.
  - Write: go to IDLE and set `done` (or go to VRD, see Configuration).
- WAIT: both strobes low. Decrement the counter each cycle. When the counter reaches 1: capture `ram_dataout`→`rdata`, set `done`, go to IDLE.
- `ram_read`/`ram_write` are decoded from state. They are never both high, and never high outside ACCESS/VRD.
- `ram_address`/`ram_datain` are held stable from acceptance until the next acceptance.
- `req` while `busy`=1 is ignored and dropped; the requester must re-assert it. The `done` cycle is IDLE, so back-to-back requests are accepted in that cycle.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `busy`, `done`, `err`, `ram_read`, `ram_write` go to 0 immediately.
  - `rdata`, `ram_address`, `ram_datain` go to 0.
  - An in-flight access is aborted. A write whose ACCESS edge has not yet occurred is not performed.

## Timing
- E0 is the edge that accepts `req`.
- Read: ACCESS in the cycle after E0. `rdata` is valid and `done`=1 in the cycle after edge E0+RD_LAT+1. With default `RD_LAT`, `done` is high 3 cycles after the request cycle.
- Write: `done`=1 in the cycle after E0+1. RAM contents update at edge E0+1.
- `busy` rises in the cycle after E0 and is low in the `done` cycle.
- `done` is registered, never combinational from `req`. `err` is valid only while `done`=1 and otherwise reads 0.

## Configuration
- `MEM_WRITE_VERIFY_EN` defined:
  - A write goes ACCESS → VRD (`ram_read`=1, same address) → VWAIT (RD_LAT cycles).
  - At the end of VWAIT, compare `ram_dataout` with `ram_datain`; `err`=mismatch and `done`=1 in the same cycle.
  - `rdata` is not updated by the verify read.
  - Write latency becomes RD_LAT+2 edges.
- Not defined: VRD/VWAIT are not generated, `err` is tied to 0, and write latency is 1 edge.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; `ram_read`=`ram_write`=0 throughout.
- Write `addr`=0x005, `wdata`=0xDEADBEEF; then read 0x005 → write `done` 2 cycles after request; read `done` 3 cycles after request with `rdata`=0xDEADBEEF; `busy` low during each `done` cycle.
- Back-to-back: issue read 0x1FF in the `done` cycle of a prior write to 0x1FF (`wdata`=0x12345678) → accepted immediately; `rdata`=0x12345678.
- `req` pulsed during WAIT with `addr`=0x0AA → ignored; `ram_address` unchanged; exactly one `done`.
- Assert `reset_n`=0 during WAIT of a read and during ACCESS of a write to 0x010 → state IDLE and strobes low immediately; `rdata`=0; a later read of 0x010 returns its prior contents.
- With `MEM_WRITE_VERIFY_EN`: write 0x020=0xA5A5A5A5 → `done` after RD_LAT+2 edges, `err`=0. Force a RAM model bit-flip on 0x020 → `err`=1 with `done`.
